// File: rtl/video_pkg.sv
// Shared types and frame geometry for the LCD framebuffer write path.
package video_pkg;

  localparam int H_PIXELS       = 160;
  localparam int V_LINES        = 144;
  localparam int BYTES_PER_LINE = H_PIXELS / 4;
  localparam int FB_BYTES       = BYTES_PER_LINE * V_LINES;
  localparam int FB_ADDR_WIDTH  = 13;

  typedef enum logic [1:0] {
    BLANK  = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } writer_state_t;

  typedef struct packed {
    logic [FB_ADDR_WIDTH-1:0] addr;
    logic [7:0]               data;
  } fb_entry_t;

  // Byte offset of the first byte of a line: line*40 built from two shifts
  // so no multiplier is needed.
  function automatic logic [FB_ADDR_WIDTH-1:0] lineBaseAddr(input logic [7:0] line);
    return {line, 5'b00000} + {2'b00, line, 3'b000};
  endfunction

endpackage

// File: rtl/fb_write_fifo.sv
// Small first-word-fall-through FIFO that buffers packed bytes on their way
// to the framebuffer RAM. The head entry is always visible on o_data.
module fb_write_fifo #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W:0]   r_wrPtr;
  logic [PTR_W:0]   r_rdPtr;
  logic             w_doPop;
  logic             w_doPush;

  assign o_empty  = (r_wrPtr == r_rdPtr);
  assign o_full   = (r_wrPtr[PTR_W] != r_rdPtr[PTR_W]) &&
                    (r_wrPtr[PTR_W-1:0] == r_rdPtr[PTR_W-1:0]);
  assign w_doPop  = i_pop & ~o_empty;
  assign w_doPush = i_push & (~o_full | w_doPop);
  assign o_data   = r_mem[r_rdPtr[PTR_W-1:0]];

  // Storage is cleared on reset so the head reads zero until the first push.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_doPush) begin
      r_mem[r_wrPtr[PTR_W-1:0]] <= i_data;
    end
  end

  // Pointers carry one extra wrap bit to tell full from empty.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + {{PTR_W{1'b0}}, 1'b1};
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + {{PTR_W{1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/lcd_framebuffer_writer.sv
// Packs the video controller's 2-bit pixels into bytes, queues them toward a
// double-banked framebuffer RAM and flips the bank once a frame is committed.
module lcd_framebuffer_writer
  import video_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = FB_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  lcd_on,
  input  logic [7:0]            line_count,
  input  logic [1:0]            pixel_data,
  input  logic                  pixel_latch,
  input  logic                  vsync,
  output logic [ADDR_WIDTH-1:0] fb_addr,
  output logic [7:0]            fb_data,
  output logic                  fb_bank,
  output logic                  fb_wr_req,
  input  logic                  fb_wr_ack,
  output logic                  frame_done,
  output logic                  overflow,
  output logic                  overrun
);

  writer_state_t r_state;
  writer_state_t w_nextState;
  logic          w_frameDoneNext;

  logic          r_prevVsync;
  logic [7:0]    r_prevLine;
  logic [7:0]    r_xCount;
  logic [5:0]    r_pack;
  logic          r_bank;
  logic          r_frameDone;
  logic          r_overflow;
  logic          r_overrun;

  logic          w_lineChange;
  logic          w_vsyncRise;
  logic          w_captureOk;
  logic          w_capture;
  logic          w_inRange;
  logic [7:0]    w_xEff;
  logic [5:0]    w_packEff;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  fb_entry_t     w_pushEntry;
  fb_entry_t     w_head;

  // A line change restarts the byte in the same cycle, so a pixel arriving
  // together with the new line number lands at x=0 of the new line.
  assign w_lineChange = (line_count != r_prevLine);
  assign w_vsyncRise  = vsync & ~r_prevVsync;
  assign w_captureOk  = (r_state == ACTIVE) && lcd_on;
  assign w_xEff       = w_lineChange ? 8'd0 : r_xCount;
  assign w_packEff    = w_lineChange ? 6'd0 : r_pack;
  assign w_capture    = w_captureOk && pixel_latch && (line_count < 8'(V_LINES));
  assign w_inRange    = (w_xEff < 8'(H_PIXELS));
  assign w_push       = w_capture && w_inRange && (w_xEff[1:0] == 2'b11);
  assign w_pop        = fb_wr_req & fb_wr_ack;

  // The fourth pixel of a group completes the byte and goes straight into the FIFO.
  always_comb begin
    w_pushEntry      = '0;
    w_pushEntry.addr = lineBaseAddr(line_count) + {7'b0000000, w_xEff[7:2]};
    w_pushEntry.data = {w_packEff, pixel_data};
  end

  fb_write_fifo #(
    .WIDTH ($bits(fb_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_data  (w_pushEntry),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign fb_wr_req  = ~w_empty;
  assign fb_addr    = ADDR_WIDTH'(w_head.addr);
  assign fb_data    = w_head.data;
  assign fb_bank    = r_bank;
  assign frame_done = r_frameDone;
  assign overflow   = r_overflow;
  assign overrun    = r_overrun;

  // Frame sequencing: wait for the top of a frame, capture, then drain the FIFO.
  always_comb begin
    w_nextState     = r_state;
    w_frameDoneNext = 1'b0;
    if (!lcd_on) begin
      w_nextState = BLANK;
    end else begin
      case (r_state)
        BLANK: begin
          if (!vsync && (line_count == 8'd0)) begin
            w_nextState = ACTIVE;
          end
        end
        ACTIVE: begin
          if (w_vsyncRise) begin
            w_nextState = DRAIN;
          end
        end
        DRAIN: begin
          if (w_empty) begin
            w_frameDoneNext = 1'b1;
            w_nextState     = BLANK;
          end
        end
        default: w_nextState = BLANK;
      endcase
    end
  end

  // State register plus the frame-complete pulse and bank flip it produces.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= BLANK;
      r_frameDone <= 1'b0;
      r_bank      <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_frameDone <= w_frameDoneNext;
      if (w_frameDoneNext) begin
        r_bank <= ~r_bank;
      end
    end
  end

  // One-cycle history of vsync and line number for edge/change detection.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_prevVsync <= 1'b0;
      r_prevLine  <= 8'd0;
    end else begin
      r_prevVsync <= vsync;
      r_prevLine  <= line_count;
    end
  end

  // Pixel column and partial byte; anything half-built outside capture is thrown away.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_xCount <= 8'd0;
      r_pack   <= 6'd0;
    end else if (!w_captureOk) begin
      r_xCount <= 8'd0;
      r_pack   <= 6'd0;
    end else if (w_capture && w_inRange) begin
      r_xCount <= w_xEff + 8'd1;
      r_pack   <= {w_packEff[3:0], pixel_data};
    end else if (w_lineChange) begin
      r_xCount <= 8'd0;
      r_pack   <= 6'd0;
    end
  end

  // Sticky error flags: a byte lost to a full FIFO, or a pixel past the line end.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (w_push && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
      if (w_capture && !w_inRange) begin
        r_overrun <= 1'b1;
      end
    end
  end

endmodule
